// File: rtl/shifter_operand_fetch.sv
// shifter_operand_fetch: decodes the ARM addressing-mode-1 field of a
// data-processing instruction into a barrel-shifter control word and fetches
// Rm/Rs through one synchronous register-file read port. The resulting
// {barrel_sel, shiftee, shifter} triple is offered to execute under a
// valid/ready handshake.
module shifter_operand_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic        rf_rd_en,
  output logic [3:0]  rf_rd_addr,
  input  logic [31:0] rf_rd_data,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [3:0]  barrel_sel,
  output logic [31:0] shiftee,
  output logic [31:0] shifter,
  output logic        op_illegal,
  input  logic        flush
);

  localparam logic [3:0] SEL_IMMED = 4'b1000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_RM  = 3'd1,
    CAP_RM = 3'd2,
    CAP_RS = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t     state_r;
  logic [3:0] rs_r;
  logic       reg_shift_r;

  // Decode of the incoming word; only meaningful while an accept happens.
  logic accept_s;
  logic dec_imm_s;
  logic dec_illegal_s;
  logic dec_reg_s;

  assign accept_s      = instr_valid & instr_ready;
  assign dec_imm_s     = instr[25];
  assign dec_illegal_s = ~instr[25] & instr[4] & instr[7];
  assign dec_reg_s     = ~instr[25] & instr[4] & ~instr[7];

  // Sequencer: every output is set on the edge that enters the state it
  // belongs to, so the read strobe is visible during RD_RM (Rm) and CAP_RM (Rs)
  // and the data returns one cycle later in CAP_RM / CAP_RS respectively.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      instr_ready <= 1'b0;
      op_valid    <= 1'b0;
      rf_rd_en    <= 1'b0;
      rf_rd_addr  <= 4'd0;
      barrel_sel  <= SEL_IMMED;
      shiftee     <= 32'd0;
      shifter     <= 32'd0;
      op_illegal  <= 1'b0;
      rs_r        <= 4'd0;
      reg_shift_r <= 1'b0;
    end else if (flush) begin
      // Abort wins over any accept or output handshake in the same cycle.
      // Data from a read already issued arrives while idle and is dropped.
      state_r     <= IDLE;
      instr_ready <= 1'b1;
      op_valid    <= 1'b0;
      rf_rd_en    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          instr_ready <= 1'b1;
          rf_rd_en    <= 1'b0;
          if (accept_s) begin
            instr_ready <= 1'b0;
            rs_r        <= instr[11:8];
            reg_shift_r <= dec_reg_s;
            op_illegal  <= dec_illegal_s;
            if (dec_imm_s) begin
              // Rotate amount is passed undoubled; the shifter doubles it.
              barrel_sel <= SEL_IMMED;
              shiftee    <= {24'd0, instr[7:0]};
              shifter    <= {28'd0, instr[11:8]};
              op_valid   <= 1'b1;
              state_r    <= OUT;
            end else if (dec_illegal_s) begin
              barrel_sel <= SEL_IMMED;
              shiftee    <= 32'd0;
              shifter    <= 32'd0;
              op_valid   <= 1'b1;
              state_r    <= OUT;
            end else begin
              barrel_sel <= {1'b0, instr[6:5], dec_reg_s};
              if (!dec_reg_s) begin
                shifter <= {27'd0, instr[11:7]};
              end else begin
                shifter <= shifter;
              end
              rf_rd_en   <= 1'b1;
              rf_rd_addr <= instr[3:0];
              state_r    <= RD_RM;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD_RM: begin
          if (reg_shift_r) begin
            rf_rd_en   <= 1'b1;
            rf_rd_addr <= rs_r;
          end else begin
            rf_rd_en <= 1'b0;
          end
          state_r <= CAP_RM;
        end
        CAP_RM: begin
          shiftee  <= rf_rd_data;
          rf_rd_en <= 1'b0;
          if (reg_shift_r) begin
            state_r <= CAP_RS;
          end else begin
            op_valid <= 1'b1;
            state_r  <= OUT;
          end
        end
        CAP_RS: begin
          shifter  <= rf_rd_data;
          rf_rd_en <= 1'b0;
          op_valid <= 1'b1;
          state_r  <= OUT;
        end
        OUT: begin
          rf_rd_en <= 1'b0;
          if (op_ready) begin
            op_valid    <= 1'b0;
            instr_ready <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= OUT;
          end
        end
        default: begin
          state_r     <= IDLE;
          instr_ready <= 1'b1;
          op_valid    <= 1'b0;
          rf_rd_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/shifter_operand_fetch.md
# shifter_operand_fetch

Sequential front end for `barrel_shifter`: accepts one ARM data-processing instruction word at a time and decodes its addressing-mode-1 field into the barrel-shifter control word `barrel_sel`. It fetches Rm and Rs through a single synchronous register-file read port and presents a stable `{barrel_sel, shiftee, shifter}` triple to the execute stage under a valid/ready handshake. It is the producer side of the barrel-shifter operand interface and sits between the decode stage and execute.

## Interface
- No parameters. Widths are fixed by the ARM ISA.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `instr_valid` in 1: `instr` holds a data-processing instruction.
- `instr` in 32: instruction word. Only bits [25], [11:0] are used.
- `instr_ready` out 1: registered; block can accept an instruction.
- `rf_rd_en` out 1: register-file read strobe.
- `rf_rd_addr` out 4: register-file read address.
- `rf_rd_data` in 32: read data, valid exactly one cycle after `rf_rd_en`=1.
- `op_valid` out 1: operand triple is valid.
- `op_ready` in 1: execute stage consumes the triple.
- `barrel_sel` out 4: shifter opcode.
- `shiftee` out 32: immed_8 zero-extended, or the Rm value.
- `shifter` out 32: rotate_imm or shift_imm zero-extended, or the Rs value.
- `op_illegal` out 1: instruction is not addressing mode 1 (I=0, bit7=1, bit4=1).
- `flush` in 1: synchronous abort of the in-flight instruction.

## Operation
- `barrel_sel` encodings:
  - IMMED=1000
  - LSLIMM=0000, LSLREG=0001
  - LSRIMM=0010, LSRREG=0011
  - ASRIMM=0100, ASRREG=0101
  - RORIMM=0110, RORREG=0111
- Decode rules:
  - I=1 (immediate): `barrel_sel`=1000, `shiftee`={24'b0, instr[7:0]}, `shifter`={28'b0, instr[11:8]}. Doubling of rotate_imm is done inside the shifter, not here.
  - I=0, bit4=0 (immediate shift): `barrel_sel`={0, instr[6:5], 0}, `shifter`={27'b0, instr[11:7]}, `shiftee`=Rm (instr[3:0]).
  - I=0, bit4=1, bit7=0 (register shift): `barrel_sel`={0, instr[6:5], 1}, `shiftee`=Rm, `shifter`=full 32-bit Rs (instr[11:8]). The shifter itself uses [7:0].
  - I=0, bit4=1, bit7=1 (illegal): `op_illegal`=1, `barrel_sel`=1000, `shiftee`=0, `shifter`=0. No register reads.
- R15 is read like any other register. PC offset is owned by the register file.
- State machine:
  - IDLE: `instr_ready`=1. Accept on `instr_valid`&`instr_ready`, latch fields. Go to OUT if immediate or illegal, else RD_RM.
  - RD_RM: `rf_rd_en`=1, `rf_rd_addr`=Rm. Go to CAP_RM.
  - CAP_RM: `shiftee`<=`rf_rd_data`. Register shift: `rf_rd_en`=1, `rf_rd_addr`=Rs, go to CAP_RS. Otherwise go to OUT.
  - CAP_RS: `shifter`<=`rf_rd_data`. Go to OUT.
  - OUT: `op_valid`=1. Outputs held stable until `op_ready`=1. On that handshake go to IDLE.
- `flush`=1 in any state: next state IDLE, `op_valid`=0, `rf_rd_en`=0, instruction discarded.
  - `flush` has priority over a simultaneous accept or output handshake; neither takes effect.
  - A read issued before the flush has its returning data ignored.
- `rf_rd_en`=0 and `rf_rd_addr` hold their last value in IDLE and OUT.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE
  - `instr_ready`=0; rises on the first `clk` edge after `reset` deasserts
  - `op_valid`=0, `rf_rd_en`=0, `rf_rd_addr`=0
  - `barrel_sel`=1000, `shiftee`=0, `shifter`=0, `op_illegal`=0
- Latency from the accept edge (cycle 0) to `op_valid`=1:
  - immediate or illegal: cycle 1
  - immediate shift: cycle 3
  - register shift: cycle 4
- `instr_ready` falls in the cycle after acceptance. It rises in the cycle after the output handshake or `flush`. No back-to-back overlap; peak throughput is 1 instruction per 2 cycles (immediate).
- `reset` asserted mid-operation: all outputs return to reset values immediately, without waiting for `clk`. The in-flight instruction is lost.
- Stall: `op_ready`=0 holds OUT indefinitely. No read strobes are issued while stalled.

## Test plan
- Reset, then `instr`=0xE3A010FF (MOV r1,#0xFF) -> `op_valid` at cycle 1: `barrel_sel`=1000, `shiftee`=0xFF, `shifter`=0. `rf_rd_en` never asserted.
- `instr`=0xE1A01142 (ASR r2 by #2), r2=0x80000000 -> `rf_rd_addr`=2 at cycle 1; `op_valid` at cycle 3 with `barrel_sel`=0100, `shiftee`=0x80000000, `shifter`=2.
- `instr`=0xE1A01312 (LSL r2 by r3), r2=0x1, r3=0x120 -> reads of 2 then 3 on consecutive cycles; `op_valid` at cycle 4 with `barrel_sel`=0001, `shiftee`=1, `shifter`=0x120.
- `instr`=0xE0010392 (MUL encoding) -> `op_valid` at cycle 1 with `op_illegal`=1, `barrel_sel`=1000, no reads.
- Hold `op_ready`=0 for 5 cycles in OUT -> triple stable and `instr_ready`=0 throughout. `op_ready`=1 -> `op_valid` falls and `instr_ready`=1 on the next cycle.
- Assert `flush` in CAP_RM, and separately `reset` during RD_RM -> IDLE with `op_valid`=0. After the flush, late `rf_rd_data` does not alter `shiftee`. Reset values appear asynchronously.
